// File: rtl/gam_node_mem_arbiter.sv
// gam_node_mem_arbiter
// Round-robin arbiter in front of the single-port GAM node memory (X/C/W/T/M).
// One requester owns the port at a time; the owner may hold it across several
// accesses with lock. Read data returns RD_LAT cycles after the strobe and is
// steered back to whoever issued the read, even after ownership has moved on.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req/lock/we [N_REQ]   per-requester request, keep-grant, write select
//   addr, wdata           per-requester slices, requester i at [i*W +: W]
//   gnt [N_REQ]           registered one-hot grant
//   rvalid [N_REQ], rdata read return (rdata broadcast, qualified by rvalid)
//   mem_*                 node-memory port (mem_rdata RD_LAT cycles after read)
//   hold_err              sticky: a locked grant was cut off at MAX_HOLD cycles
//
// state | meaning
// IDLE  | no owner; arbitrate among pending requests from rr_ptr upward
// BUSY  | owner holds the port; its request/we/addr/wdata drive the memory
module gam_node_mem_arbiter #(
    parameter int N_REQ    = 3,
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_HOLD = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        lock,
    input  logic [N_REQ-1:0]        we,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    hold_err
);

    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   rr_ptr;
    logic [HW-1:0]   hold_cnt;

    // read tag pipeline: stage k holds the read issued k cycles ago
    logic [RD_LAT:1] tag_v;
    logic [OW-1:0]   tag_o [1:RD_LAT];

    logic [ADDR_W-1:0] addr_a  [N_REQ];
    logic [DATA_W-1:0] wdata_a [N_REQ];

    logic          pick_found;
    logic [OW-1:0] pick_idx;
    logic          busy;
    logic          hold_last;
    logic          release_now;
    logic          rd_issue;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
            wdata_a[i] = wdata[i*DATA_W +: DATA_W];
        end
    end

    // first pending request at or after rr_ptr, wrapping at N_REQ
    always_comb begin
        int cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!pick_found && req[OW'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = OW'(cand);
            end
        end
    end

    // the memory port follows the owner combinationally so the first access
    // lands in the same cycle the registered grant appears
    always_comb begin
        busy        = (state == BUSY);
        mem_en      = busy & req[owner];
        mem_we      = mem_en & we[owner];
        mem_addr    = busy ? addr_a[owner]  : '0;
        mem_wdata   = busy ? wdata_a[owner] : '0;
        rd_issue    = mem_en & ~we[owner];
        hold_last   = (hold_cnt == HW'(MAX_HOLD - 1));
        release_now = ~req[owner] | ~lock[owner] | hold_last;
    end

    always_comb begin
        rvalid = tag_v[RD_LAT] ? (N_REQ'(1) << tag_o[RD_LAT]) : '0;
        rdata  = tag_v[RD_LAT] ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            hold_err <= 1'b0;
            tag_v    <= '0;
            for (int k = 1; k <= RD_LAT; k++) tag_o[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner    <= pick_idx;
                        gnt      <= N_REQ'(1) << pick_idx;
                        hold_cnt <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_last && lock[owner]) hold_err <= 1'b1;
                    if (release_now) begin
                        state  <= IDLE;
                        gnt    <= '0;
                        rr_ptr <= (owner == OW'(N_REQ - 1)) ? '0 : owner + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            tag_v[1] <= rd_issue;
            tag_o[1] <= owner;
            for (int k = 2; k <= RD_LAT; k++) begin
                tag_v[k] <= tag_v[k-1];
                tag_o[k] <= tag_o[k-1];
            end
        end
    end

endmodule

// File: tb/tb_gam_node_mem_arbiter.sv
module tb_gam_node_mem_arbiter;

    localparam int N = 3;
    localparam int AW = 10;
    localparam int DW = 32;
    // two configurations share one stimulus stream
    localparam int RL0 = 1, MH0 = 64;
    localparam int RL1 = 3, MH1 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [N-1:0]    req, lock, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0]   mem_rdata;

    logic [N-1:0]  gnt_o      [2];
    logic [N-1:0]  rvalid_o   [2];
    logic [DW-1:0] rdata_o    [2];
    logic          mem_en_o   [2];
    logic          mem_we_o   [2];
    logic [AW-1:0] mem_addr_o [2];
    logic [DW-1:0] mem_wdata_o[2];
    logic          hold_err_o [2];

    gam_node_mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL0), .MAX_HOLD(MH0)) u_a (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt_o[0]), .rvalid(rvalid_o[0]), .rdata(rdata_o[0]), .mem_en(mem_en_o[0]),
        .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]), .mem_wdata(mem_wdata_o[0]),
        .mem_rdata(mem_rdata), .hold_err(hold_err_o[0]));

    gam_node_mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL1), .MAX_HOLD(MH1)) u_b (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt_o[1]), .rvalid(rvalid_o[1]), .rdata(rdata_o[1]), .mem_en(mem_en_o[1]),
        .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]), .mem_wdata(mem_wdata_o[1]),
        .mem_rdata(mem_rdata), .hold_err(hold_err_o[1]));

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int due;
        int own;
    } rd_t;
    rd_t q0[$];
    rd_t q1[$];

    // reference model: who owns the port, whose turn is next, how long held
    bit m_known = 0;
    bit m_post_rst = 0;
    bit rst_seen = 0;
    bit m_busy [2];
    int m_own  [2];
    int m_prio [2];
    int m_cnt  [2];
    bit m_err  [2];
    bit fixed_md = 0;

    task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d actual=%0h required=%0h", nm, c, cyc, act, exp);
        end
    endtask

    function automatic int rlat(input int c);
        return (c == 0) ? RL0 : RL1;
    endfunction

    function automatic int mhold(input int c);
        return (c == 0) ? MH0 : MH1;
    endfunction

    task automatic model_cycle();
        for (int c = 0; c < 2; c++) begin
            bit en;
            int o;
            o  = m_own[c];
            en = m_busy[c] && req[o];
            if (m_known) begin
                chk("gnt", c, 64'(gnt_o[c]), m_busy[c] ? 64'(1) << o : 64'd0);
                chk("mem_en", c, 64'(mem_en_o[c]), 64'(en));
                chk("hold_err", c, 64'(hold_err_o[c]), 64'(m_err[c]));
                if (en) begin
                    chk("mem_we", c, 64'(mem_we_o[c]), 64'(we[o]));
                    chk("mem_addr", c, 64'(mem_addr_o[c]), 64'(addr[o*AW +: AW]));
                    chk("mem_wdata", c, 64'(mem_wdata_o[c]), 64'(wdata[o*DW +: DW]));
                end
                if (m_post_rst) begin
                    chk("rst_mem_we", c, 64'(mem_we_o[c]), 64'd0);
                    chk("rst_mem_addr", c, 64'(mem_addr_o[c]), 64'd0);
                    chk("rst_mem_wdata", c, 64'(mem_wdata_o[c]), 64'd0);
                    chk("rst_rdata", c, 64'(rdata_o[c]), 64'd0);
                end
            end
            if (reset) begin
                m_busy[c] = 0; m_own[c] = 0; m_prio[c] = 0; m_cnt[c] = 0; m_err[c] = 0;
            end else if (m_known) begin
                if (!m_busy[c]) begin
                    for (int k = 0; k < N; k++) begin
                        int idx;
                        idx = (m_prio[c] + k) % N;
                        if (!m_busy[c] && req[idx]) begin
                            m_busy[c] = 1; m_own[c] = idx; m_cnt[c] = 0;
                        end
                    end
                end else begin
                    if (en && !we[o]) begin
                        rd_t e;
                        e.due = cyc + rlat(c);
                        e.own = o;
                        if (c == 0) q0.push_back(e); else q1.push_back(e);
                    end
                    if (m_cnt[c] == mhold(c) - 1 && lock[o]) m_err[c] = 1;
                    if (!req[o] || !lock[o] || m_cnt[c] == mhold(c) - 1) begin
                        m_busy[c] = 0;
                        m_prio[c] = (o + 1) % N;
                    end
                    m_cnt[c]++;
                end
            end
        end
        rst_seen = reset;
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        cyc++;
        m_post_rst = rst_seen;
        if (rst_seen) begin
            m_known = 1;
            q0.delete();
            q1.delete();
        end
        #1;
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N-1:0] w);
        req  = r;
        lock = l;
        we   = w;
        addr = {$urandom, $urandom}[N*AW-1:0];
        wdata = {$urandom, $urandom, $urandom};
        if (!fixed_md) mem_rdata = $urandom;
    endtask

    // read-return monitor: pops the scoreboard whenever a return is due
    task automatic mon(input int c);
        rd_t e;
        bit has;
        has = 0;
        if (c == 0 && q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); has = 1; end
        if (c == 1 && q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); has = 1; end
        if (has) begin
            chk("rvalid", c, 64'(rvalid_o[c]), 64'(1) << e.own);
            chk("rdata", c, 64'(rdata_o[c]), 64'(mem_rdata));
        end else begin
            chk("rvalid_idle", c, 64'(rvalid_o[c]), 64'd0);
        end
    endtask

    always begin
        @(negedge clk);
        #1;
        if (m_known) begin
            mon(0);
            mon(1);
        end
    end

    initial begin
        reset = 1'b1;
        mem_rdata = '0;
        drive('0, '0, '0);
        repeat (3) step();
        reset = 1'b0;

        // single unlocked read from requester 0 at address 5
        fixed_md = 1; mem_rdata = 32'hA5;
        drive(3'b001, 3'b000, 3'b000);
        addr[AW-1:0] = 10'd5;
        step();
        drive(3'b001, 3'b000, 3'b000);
        addr[AW-1:0] = 10'd5;
        step();
        repeat (4) begin drive('0, '0, '0); step(); end
        fixed_md = 0;

        // all three requesting, unlocked
        repeat (10) begin drive(3'b111, 3'b000, 3'b000); step(); end
        repeat (3) begin drive('0, '0, '0); step(); end

        // requester 0 locked reads then a releasing write, requester 1 waiting
        repeat (4) begin drive(3'b011, 3'b001, 3'b000); step(); end
        drive(3'b011, 3'b000, 3'b001); step();
        repeat (4) begin drive(3'b010, 3'b000, 3'b000); step(); end
        repeat (4) begin drive('0, '0, '0); step(); end

        // requester 2 never lets go: both hold limits trip
        repeat (75) begin drive(3'b101, 3'b100, 3'b000); step(); end
        repeat (4) begin drive(3'b001, 3'b000, 3'b000); step(); end
        repeat (4) begin drive('0, '0, '0); step(); end

        // read in flight while the next owner is already issuing
        drive(3'b010, 3'b000, 3'b000); step();
        drive(3'b011, 3'b000, 3'b000); step();
        repeat (6) begin drive(3'b001, 3'b001, 3'b000); step(); end
        repeat (6) begin drive('0, '0, '0); step(); end

        // reset right behind a read
        repeat (2) begin drive(3'b001, 3'b001, 3'b000); step(); end
        reset = 1'b1;
        drive(3'b001, 3'b001, 3'b000); step();
        reset = 1'b0;
        repeat (4) begin drive(3'b111, 3'b000, 3'b000); step(); end
        repeat (4) begin drive('0, '0, '0); step(); end

        // random traffic with lock biased high and rare resets
        repeat (3000) begin
            logic [N-1:0] l;
            for (int b = 0; b < N; b++) l[b] = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 399) == 0);
            drive(N'($urandom_range(0, 7)), l, N'($urandom_range(0, 7)));
            step();
        end
        reset = 1'b0;
        repeat (10) begin drive('0, '0, '0); step(); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
